if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter: NOP_INSTR, default 32'h00000013, bubble instruction driven on killed or empty slots.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 PC_rst  input  32  reset/boot fetch address, sampled only while rst=1.
REQ-005 stall  input  1  downstream (IF2EXE) not accepting; hold current fetch slot.
REQ-006 redirect  input  1  taken branch/jump resolved in EXE; flush wrong-path fetch.
REQ-007 redirect_pc  input  32  target address, valid when redirect=1.
REQ-008 imem_addr  output  32  instruction memory read address, = pc_q combinationally.
REQ-009 imem_rdata  input  32  synchronous IMEM read data, 1-cycle latency after imem_addr.
REQ-010 instruction_out  output  32  fetched instruction to IF2EXE.
REQ-011 PC_out  output  32  address of instruction_out (pc_d1).
REQ-012 valid_out  output  1  instruction_out is a real, non-killed instruction.

Function
REQ-013 Internal state: pc_q (address presented), pc_d1 (address of data on imem_rdata), hold_q (32b), state in {FILL, RUN, HOLD}.
REQ-014 FILL: instruction_out=NOP_INSTR, valid_out=0; no stall -> pc_d1<=pc_q, pc_q<=pc_q+4, go RUN; stall -> stay FILL, pc_q held.
REQ-015 RUN, stall=0: instruction_out=imem_rdata, PC_out=pc_d1, valid_out=1; pc_d1<=pc_q, pc_q<=pc_q+4; stay RUN.
REQ-016 RUN, stall=1: same outputs as REQ-015; hold_q<=imem_rdata; pc_q, pc_d1 held; go HOLD.
REQ-017 HOLD: instruction_out=hold_q, PC_out=pc_d1, valid_out=1; stall=1 -> stay; stall=0 -> pc_d1<=pc_q, pc_q<=pc_q+4, go RUN.
REQ-018 Outputs SHALL remain bit-stable across every consecutive stall cycle.
REQ-019 redirect=1 in any state: pc_q<=redirect_pc, go FILL; same-cycle outputs instruction_out=NOP_INSTR, valid_out=0.
REQ-020 redirect and stall both high: redirect wins; stall ignored that cycle.
REQ-021 Redirect penalty: exactly 2 bubble cycles (redirect cycle + FILL), first target instruction valid on 2nd cycle after redirect with no stall.
REQ-022 pc_q+4 computed modulo 2^32; 32'hFFFFFFFC wraps to 32'h00000000.
REQ-023 redirect_pc used as-is; bits [1:0] not checked or masked.
REQ-024 Steady-state throughput: one valid instruction per cycle with stall=0, redirect=0.

Reset
REQ-025 rst=1 at any edge, any state: pc_q<=PC_rst, pc_d1<=PC_rst, hold_q<=NOP_INSTR, state<=FILL; overrides redirect and stall.
REQ-026 During rst and first cycle after: valid_out=0, instruction_out=NOP_INSTR, imem_addr=PC_rst.
REQ-027 First valid instruction (address PC_rst) on 2nd cycle after rst deasserts, stall=0.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN defined: add outputs fetch_count[31:0] and kill_count[31:0].
REQ-029 fetch_count increments each cycle valid_out=1 and stall=0 and redirect=0; kill_count increments each cycle redirect=1; both reset to 0 on rst, wrap at 2^32.
REQ-030 Macro undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-031 PC_rst=32'h00001000, release rst, no stall -> valid_out=0 for 2 cycles, then PC_out 1000,1004,1008 on consecutive cycles with matching IMEM words.
REQ-032 Stall 3 cycles while PC_out=1008 -> instruction_out/PC_out/valid_out constant all 3 cycles; after release next PC_out=100C, no skip or duplicate.
REQ-033 redirect=1, redirect_pc=32'h00002000 while PC_out=1010 -> valid_out=0 that cycle and next, then PC_out=2000 valid.
REQ-034 redirect and stall high together in HOLD -> redirect taken, FILL entered, PC_out=target 2 cycles later.
REQ-035 redirect_pc=32'hFFFFFFFC -> PC_out FFFFFFFC then 00000000.
REQ-036 rst asserted mid-HOLD -> next cycle state FILL, imem_addr=PC_rst, valid_out=0; with FETCH_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: drives IMEM address, aligns sync read data with its PC, hides IMEM latency.
// Latency: first instruction 2 cycles after reset release or redirect; then 1 instruction per cycle.
// Backpressure: stall holds the presented slot bit-stable (captured in hold_q); redirect overrides stall.
// Optional: define FETCH_PERF_CNT_EN to add fetch_count/kill_count performance counters.
module if_fetch_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] PC_out,
    output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] kill_count
`endif
);

    // FILL: waiting for the first IMEM word of a new stream.
    // RUN:  imem_rdata belongs to pc_d1 and is forwarded directly.
    // HOLD: downstream stalled; the word for pc_d1 lives in hold_q because
    //       imem_rdata has already moved on to the word at pc_q.
    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] pc_d1;
    logic [31:0] hold_q;
    logic [31:0] pc_next;

    // Sequential address increment wraps naturally at 2^32.
    assign pc_next = pc_q + 32'd4;

    // Fetch state machine: reset beats redirect, redirect beats stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= PC_rst;
            pc_d1  <= PC_rst;
            hold_q <= NOP_INSTR;
            state  <= FILL;
        end else if (redirect) begin
            pc_q  <= redirect_pc;
            state <= FILL;
        end else begin
            case (state)
                FILL: begin
                    if (!stall) begin
                        pc_d1 <= pc_q;
                        pc_q  <= pc_next;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stall) begin
                        hold_q <= imem_rdata;
                        state  <= HOLD;
                    end else begin
                        pc_d1 <= pc_q;
                        pc_q  <= pc_next;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_d1 <= pc_q;
                        pc_q  <= pc_next;
                        state <= RUN;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Output slot select; reset and redirect force a bubble in the same cycle.
    always_comb begin
        imem_addr       = rst ? PC_rst : pc_q;
        PC_out          = pc_d1;
        instruction_out = NOP_INSTR;
        valid_out       = 1'b0;
        if (!rst && !redirect) begin
            case (state)
                RUN: begin
                    instruction_out = imem_rdata;
                    valid_out       = 1'b1;
                end
                HOLD: begin
                    instruction_out = hold_q;
                    valid_out       = 1'b1;
                end
                default: begin
                    instruction_out = NOP_INSTR;
                    valid_out       = 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Count accepted instructions and redirect (kill) cycles; both wrap at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 32'd0;
            kill_count  <= 32'd0;
        end else begin
            if (valid_out && !stall && !redirect) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect) begin
                kill_count <= kill_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, streaming, stall hold, redirect, wrap, reset in HOLD.
// IMEM model returns addr ^ 32'hDEAD0000 one cycle after the address is presented.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instruction_out;
    logic [31:0] PC_out;
    logic        valid_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] kill_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [64:0] snap;

    if_fetch_stage #(.NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .PC_rst          (PC_rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .instruction_out (instruction_out),
        .PC_out          (PC_out),
        .valid_out       (valid_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .kill_count      (kill_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous IMEM with 1-cycle read latency.
    always @(posedge clk) imem_rdata <= imem_addr ^ 32'hDEAD0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; PC_rst = 32'h00001000; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        tick(); tick();
        #1;
        n_cmp++;
        if ({valid_out, instruction_out, imem_addr} !== {1'b0, NOP, 32'h00001000}) begin
            n_err++;
            $display("FAIL rst_active: got v=%b i=%h a=%h want v=0 i=%h a=00001000", valid_out, instruction_out, imem_addr, NOP);
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({valid_out, instruction_out, imem_addr} !== {1'b0, NOP, 32'h00001000}) begin
            n_err++;
            $display("FAIL rst_first_after: got v=%b i=%h a=%h want v=0 i=%h a=00001000", valid_out, instruction_out, imem_addr, NOP);
        end
    endtask

    task automatic test_stream();
        tick(); #1;
        n_cmp++;
        if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'h00001000, 32'hDEAD1000}) begin
            n_err++;
            $display("FAIL stream_1000: got v=%b pc=%h i=%h want v=1 pc=00001000 i=DEAD1000", valid_out, PC_out, instruction_out);
        end
        tick(); #1;
        n_cmp++;
        if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'h00001004, 32'hDEAD1004}) begin
            n_err++;
            $display("FAIL stream_1004: got v=%b pc=%h i=%h want v=1 pc=00001004 i=DEAD1004", valid_out, PC_out, instruction_out);
        end
    endtask

    task automatic test_stall();
        tick();
        stall = 1'b1;
        #1;
        n_cmp++;
        if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'h00001008, 32'hDEAD1008}) begin
            n_err++;
            $display("FAIL stall_first_1008: got v=%b pc=%h i=%h want v=1 pc=00001008 i=DEAD1008", valid_out, PC_out, instruction_out);
        end
        snap = {valid_out, PC_out, instruction_out};
        for (int k = 0; k < 2; k++) begin
            tick(); #1;
            n_cmp++;
            if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'h00001008, 32'hDEAD1008}) begin
                n_err++;
                $display("FAIL stall_hold_%0d: got v=%b pc=%h i=%h want v=1 pc=00001008 i=DEAD1008", k, valid_out, PC_out, instruction_out);
            end
            n_cmp++;
            if ({valid_out, PC_out, instruction_out} !== snap) begin
                n_err++;
                $display("FAIL stall_stable_%0d: got %h want %h", k, {valid_out, PC_out, instruction_out}, snap);
            end
        end
        tick();
        stall = 1'b0;
        #1;
        n_cmp++;
        if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'h00001008, 32'hDEAD1008}) begin
            n_err++;
            $display("FAIL stall_release_1008: got v=%b pc=%h i=%h want v=1 pc=00001008 i=DEAD1008", valid_out, PC_out, instruction_out);
        end
        tick(); #1;
        n_cmp++;
        if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'h0000100C, 32'hDEAD100C}) begin
            n_err++;
            $display("FAIL after_stall_100c: got v=%b pc=%h i=%h want v=1 pc=0000100C i=DEAD100C", valid_out, PC_out, instruction_out);
        end
    endtask

    task automatic test_redirect();
        tick();
        #1;
        n_cmp++;
        if ({valid_out, PC_out} !== {1'b1, 32'h00001010}) begin
            n_err++;
            $display("FAIL pre_redirect_1010: got v=%b pc=%h want v=1 pc=00001010", valid_out, PC_out);
        end
        redirect = 1'b1; redirect_pc = 32'h00002000;
        #1;
        n_cmp++;
        if ({valid_out, instruction_out} !== {1'b0, NOP}) begin
            n_err++;
            $display("FAIL redirect_bubble0: got v=%b i=%h want v=0 i=%h", valid_out, instruction_out, NOP);
        end
        tick();
        redirect = 1'b0;
        #1;
        n_cmp++;
        if ({valid_out, instruction_out, imem_addr} !== {1'b0, NOP, 32'h00002000}) begin
            n_err++;
            $display("FAIL redirect_bubble1: got v=%b i=%h a=%h want v=0 i=%h a=00002000", valid_out, instruction_out, imem_addr, NOP);
        end
        tick(); #1;
        n_cmp++;
        if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'h00002000, 32'hDEAD2000}) begin
            n_err++;
            $display("FAIL redirect_target: got v=%b pc=%h i=%h want v=1 pc=00002000 i=DEAD2000", valid_out, PC_out, instruction_out);
        end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        tick(); #1;
        n_cmp++;
        if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'h00002000, 32'hDEAD2000}) begin
            n_err++;
            $display("FAIL hold_2000: got v=%b pc=%h i=%h want v=1 pc=00002000 i=DEAD2000", valid_out, PC_out, instruction_out);
        end
        redirect = 1'b1; redirect_pc = 32'h00003000;
        #1;
        n_cmp++;
        if ({valid_out, instruction_out} !== {1'b0, NOP}) begin
            n_err++;
            $display("FAIL redir_stall_bubble: got v=%b i=%h want v=0 i=%h", valid_out, instruction_out, NOP);
        end
        tick();
        redirect = 1'b0; stall = 1'b0;
        #1;
        n_cmp++;
        if ({valid_out, imem_addr} !== {1'b0, 32'h00003000}) begin
            n_err++;
            $display("FAIL redir_stall_fill: got v=%b a=%h want v=0 a=00003000", valid_out, imem_addr);
        end
        tick(); #1;
        n_cmp++;
        if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'h00003000, 32'hDEAD3000}) begin
            n_err++;
            $display("FAIL redir_stall_target: got v=%b pc=%h i=%h want v=1 pc=00003000 i=DEAD3000", valid_out, PC_out, instruction_out);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
        #1;
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_redirect: got v=%b want v=0", valid_out);
        end
        tick();
        redirect = 1'b0; stall = 1'b1;
        #1;
        n_cmp++;
        if ({valid_out, imem_addr} !== {1'b0, 32'hFFFFFFFC}) begin
            n_err++;
            $display("FAIL fill_stall_0: got v=%b a=%h want v=0 a=FFFFFFFC", valid_out, imem_addr);
        end
        tick();
        stall = 1'b0;
        #1;
        n_cmp++;
        if ({valid_out, imem_addr} !== {1'b0, 32'hFFFFFFFC}) begin
            n_err++;
            $display("FAIL fill_stall_1: got v=%b a=%h want v=0 a=FFFFFFFC", valid_out, imem_addr);
        end
        tick(); #1;
        n_cmp++;
        if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'hFFFFFFFC, 32'h2152FFFC}) begin
            n_err++;
            $display("FAIL wrap_top: got v=%b pc=%h i=%h want v=1 pc=FFFFFFFC i=2152FFFC", valid_out, PC_out, instruction_out);
        end
        tick(); #1;
        n_cmp++;
        if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'h00000000, 32'hDEAD0000}) begin
            n_err++;
            $display("FAIL wrap_zero: got v=%b pc=%h i=%h want v=1 pc=00000000 i=DEAD0000", valid_out, PC_out, instruction_out);
        end
    endtask

    task automatic test_reset_in_hold();
        stall = 1'b1;
        tick(); #1;
        n_cmp++;
        if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'h00000000, 32'hDEAD0000}) begin
            n_err++;
            $display("FAIL hold_zero: got v=%b pc=%h i=%h want v=1 pc=00000000 i=DEAD0000", valid_out, PC_out, instruction_out);
        end
        rst = 1'b1; PC_rst = 32'h00005000; redirect = 1'b1; redirect_pc = 32'h00007000;
        #1;
        n_cmp++;
        if ({valid_out, imem_addr} !== {1'b0, 32'h00005000}) begin
            n_err++;
            $display("FAIL rst_hold_active: got v=%b a=%h want v=0 a=00005000", valid_out, imem_addr);
        end
        tick();
        rst = 1'b0; redirect = 1'b0; stall = 1'b0;
        #1;
        n_cmp++;
        if ({valid_out, instruction_out, imem_addr} !== {1'b0, NOP, 32'h00005000}) begin
            n_err++;
            $display("FAIL rst_hold_fill: got v=%b i=%h a=%h want v=0 i=%h a=00005000", valid_out, instruction_out, imem_addr, NOP);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if ({fetch_count, kill_count} !== 64'd0) begin
            n_err++;
            $display("FAIL cnt_after_rst: got f=%0d k=%0d want f=0 k=0", fetch_count, kill_count);
        end
`endif
        tick(); #1;
        n_cmp++;
        if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'h00005000, 32'hDEAD5000}) begin
            n_err++;
            $display("FAIL rst_hold_first: got v=%b pc=%h i=%h want v=1 pc=00005000 i=DEAD5000", valid_out, PC_out, instruction_out);
        end
        tick(); #1;
        n_cmp++;
        if ({valid_out, PC_out, instruction_out} !== {1'b1, 32'h00005004, 32'hDEAD5004}) begin
            n_err++;
            $display("FAIL rst_hold_second: got v=%b pc=%h i=%h want v=1 pc=00005004 i=DEAD5004", valid_out, PC_out, instruction_out);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if ({fetch_count, kill_count} !== {32'd1, 32'd0}) begin
            n_err++;
            $display("FAIL cnt_one_fetch: got f=%0d k=%0d want f=1 k=0", fetch_count, kill_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
